past_notes_replay: RTL and testbench

- Downstream consumer of the past-notes history shift chain (5 x 4-bit stages, newest in slot 0).
- On a replay request, snapshots the history and replays it oldest-first as a timed note stream.
- Each note is held for a programmable number of cycles; rest slots are skipped.
- Output feeds the note player with the same note/new-note pulse pairing the shift chain consumes.

---
 rtl/past_notes_replay_pkg.sv | 19 +
 rtl/dffre.sv | 19 +
 rtl/past_notes_replay_dur_counter.sv | 34 +++
 rtl/past_notes_replay.sv | 124 ++++++++++++
 tb/tb_past_notes_replay.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/past_notes_replay_pkg.sv
// past_notes_replay_pkg
//   Shared definitions for the past-notes replay block: default widths,
//   the rest-note code and the replay FSM state encoding.
package past_notes_replay_pkg;

    localparam int NOTE_W = 4;   // width of one note code
    localparam int DEPTH  = 5;   // history slots replayed
    localparam int DUR_W  = 11;  // hold-duration counter width

    localparam logic [NOTE_W-1:0] NOTE_REST = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEEK = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } replay_state_t;

endpackage

// File: rtl/dffre.sv
// dffre
//   Flop with async active-low reset (to zero) and synchronous enable.
//   Ports: clk, rst_n, en, d[W-1:0] -> q[W-1:0]
module dffre #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/past_notes_replay_dur_counter.sv
// replay_dur_counter
//   Loadable down-counter holding the remaining cycles of a replayed note.
//   Load has priority over decrement; decrement stops at zero so the count
//   never wraps.
//   Ports: clk, rst_n, i_load, i_load_val[DUR_W-1:0], i_dec
//          -> o_cnt[DUR_W-1:0], o_zero
module replay_dur_counter #(
    parameter int DUR_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [DUR_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [DUR_W-1:0] o_cnt,
    output logic             o_zero
);

    logic             w_en;
    logic [DUR_W-1:0] w_d;

    assign o_zero = (o_cnt == '0);
    assign w_en   = i_load | (i_dec & ~o_zero);
    assign w_d    = i_load ? i_load_val : (o_cnt - DUR_W'(1));

    dffre #(.W(DUR_W)) u_cnt_q (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_en),
        .d     (w_d),
        .q     (o_cnt)
    );

endmodule

// File: rtl/past_notes_replay.sv
// past_notes_replay
//   Snapshots the past-notes history on a replay request and plays it back
//   oldest-first, each non-rest note held for max(dur_in,1) cycles after a
//   one-cycle seek. Rest slots are skipped at one cycle each.
//   Ports:
//     clk, reset (async, active low)
//     play_enable   - run; low freezes SEEK/HOLD in place
//     replay_start  - start request, sampled only in IDLE
//     notes_in      - history bus, slot 0 newest, slot DEPTH-1 oldest
//     dur_in        - hold cycles, sampled when a note is launched
//     note_out      - replayed note (registered)
//     new_note      - one-cycle pulse when note_out takes a new note
//     busy          - state != IDLE
//     done          - high for the single DONE cycle
module past_notes_replay
    import past_notes_replay_pkg::*;
#(
    parameter int P_NOTE_W = NOTE_W,
    parameter int P_DEPTH  = DEPTH,
    parameter int P_DUR_W  = DUR_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        play_enable,
    input  logic                        replay_start,
    input  logic [P_DEPTH*P_NOTE_W-1:0] notes_in,
    input  logic [P_DUR_W-1:0]          dur_in,
    output logic [P_NOTE_W-1:0]         note_out,
    output logic                        new_note,
    output logic                        busy,
    output logic                        done
);

    localparam int IDX_W = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;

    replay_state_t                          r_state;
    logic [IDX_W-1:0]                       r_idx;
    logic [P_DEPTH-1:0][P_NOTE_W-1:0]       r_snap;
    logic [P_NOTE_W-1:0]                    r_note_out;
    logic                                   r_new_note;

    logic [P_NOTE_W-1:0]                    w_cur;
    logic                                   w_cur_rest;
    logic [P_DUR_W-1:0]                     w_load_val;
    logic                                   w_load;
    logic                                   w_dec;
    logic                                   w_zero;
    logic [P_DUR_W-1:0]                     w_cnt;

    assign w_cur      = r_snap[r_idx];
    assign w_cur_rest = (w_cur == NOTE_REST[P_NOTE_W-1:0]);

    // dur_in = 0 behaves as 1: the SEEK->HOLD edge already counts as one
    // hold cycle, so the counter is loaded with the remaining cycles.
    assign w_load_val = (dur_in == '0) ? '0 : (dur_in - P_DUR_W'(1));
    assign w_load     = (r_state == ST_SEEK) && play_enable && !w_cur_rest;
    assign w_dec      = (r_state == ST_HOLD) && play_enable;

    replay_dur_counter #(.DUR_W(P_DUR_W)) u_dur_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_cnt      (w_cnt),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_snap     <= '0;
            r_note_out <= '0;
            r_new_note <= 1'b0;
        end else begin
            r_new_note <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (replay_start) begin
                        r_snap  <= notes_in;
                        r_idx   <= IDX_W'(P_DEPTH - 1);
                        r_state <= ST_SEEK;
                    end
                end
                ST_SEEK: begin
                    if (play_enable) begin
                        if (!w_cur_rest) begin
                            r_note_out <= w_cur;
                            r_new_note <= 1'b1;
                            r_state    <= ST_HOLD;
                        end else if (r_idx == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx <= r_idx - IDX_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    // Counter decrements inside u_dur_cnt; leave only once it is drained.
                    if (play_enable && w_zero) begin
                        if (r_idx == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx - IDX_W'(1);
                            r_state <= ST_SEEK;
                        end
                    end
                end
                ST_DONE: begin
                    r_note_out <= '0;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign note_out = r_note_out;
    assign new_note = r_new_note;
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_past_notes_replay.sv
module tb_past_notes_replay;
    import past_notes_replay_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      play_enable;
    logic                      replay_start;
    logic [DEPTH*NOTE_W-1:0]   notes_in;
    logic [DUR_W-1:0]          dur_in;
    logic [NOTE_W-1:0]         note_out;
    logic                      new_note;
    logic                      busy;
    logic                      done;

    past_notes_replay dut (
        .clk          (clk),
        .reset        (reset),
        .play_enable  (play_enable),
        .replay_start (replay_start),
        .notes_in     (notes_in),
        .dur_in       (dur_in),
        .note_out     (note_out),
        .new_note     (new_note),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              is_done;
        int              tick;
        logic [NOTE_W-1:0] note;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  passes = 0;
    int  done_cnt = 0;
    int  pulse_cnt = 0;
    int  tick = 0;
    bit  tb_launch = 1'b0;

    // Enabled edges since the start edge: the replay only advances on these.
    always @(posedge clk) begin
        if (tb_launch)        tick <= 0;
        else if (play_enable) tick <= tick + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: oldest slot first; each slot takes one enabled SEEK edge,
    // a note additionally occupies max(dur,1) enabled HOLD edges.
    task automatic model(input logic [DEPTH*NOTE_W-1:0] n, input int d);
        int  t = 0;
        ev_t e;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            logic [NOTE_W-1:0] s;
            s = n[i*NOTE_W +: NOTE_W];
            t++;
            if (s != 0) begin
                e.is_done = 0; e.tick = t; e.note = s;
                sb.push_back(e);
                t += (d == 0) ? 1 : d;
            end
        end
        e.is_done = 1; e.tick = t; e.note = '0;
        sb.push_back(e);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (reset) begin
            if (new_note) begin
                pulse_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL pulse_unexpected: note %0d with empty scoreboard", note_out);
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    chk("pulse_kind", int'(e.is_done), 0);
                    chk("pulse_note", int'(note_out), int'(e.note));
                    chk("pulse_tick", tick, e.tick);
                end
            end
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL done_unexpected: done with empty scoreboard");
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    chk("done_kind", int'(e.is_done), 1);
                    chk("done_tick", tick, e.tick);
                end
            end
        end
    end

    task automatic start(input logic [DEPTH*NOTE_W-1:0] n, input int d);
        @(negedge clk);
        notes_in     = n;
        dur_in       = DUR_W'(d);
        replay_start = 1'b1;
        tb_launch    = 1'b1;
        model(n, d);
        @(negedge clk);
        replay_start = 1'b0;
        tb_launch    = 1'b0;
    endtask

    // mode 0: steady run, 1: random enable + history churn + stray starts,
    // 2: 4-cycle pause after edge 2, 3: history overwrite + stray start
    task automatic wait_done(input int mode);
        int base = done_cnt;
        int cyc  = 0;
        while (done_cnt == base && cyc < 3000) begin
            @(negedge clk); #1;
            cyc++;
            if (done_cnt != base) break;
            case (mode)
                1: begin
                    play_enable  = ($urandom_range(0, 3) != 0);
                    notes_in     = (DEPTH*NOTE_W)'($urandom);
                    replay_start = ($urandom_range(0, 5) == 0);
                end
                2: play_enable = !(cyc >= 2 && cyc <= 5);
                3: begin
                    if (cyc == 3) notes_in = '1;
                    replay_start = (cyc == 6);
                end
                default: ;
            endcase
        end
        replay_start = 1'b0;
        play_enable  = 1'b1;
        if (done_cnt == base) begin
            checks++;
            $display("FAIL timeout: no done within %0d cycles", cyc);
        end
        @(negedge clk); #1;
        chk("idle_busy", int'(busy), 0);
        chk("idle_note", int'(note_out), 0);
        chk("idle_done", int'(done), 0);
        chk("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    localparam logic [DEPTH*NOTE_W-1:0] FULL = {4'd4, 4'd5, 4'd9, 4'd10, 4'd14};
    localparam logic [DEPTH*NOTE_W-1:0] RSTS = {4'd4, 4'd0, 4'd9, 4'd0, 4'd14};

    initial begin
        int pbase;
        int dbase;
        int w;
        reset        = 1'b0;
        play_enable  = 1'b1;
        replay_start = 1'b0;
        notes_in     = '0;
        dur_in       = '0;
        #12;
        chk("rst_note", int'(note_out), 0);
        chk("rst_new_note", int'(new_note), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b1;

        start(FULL, 3); wait_done(0);   // full replay
        start(RSTS, 2); wait_done(0);   // rest skip
        start(FULL, 3); wait_done(2);   // pause
        dbase = done_cnt;
        start(FULL, 3); wait_done(3);   // snapshot isolation + ignored start
        chk("single_done", done_cnt - dbase, 1);
        start(FULL, 0); wait_done(0);   // dur 0 -> period 2
        pbase = pulse_cnt;
        start('0, 5); wait_done(0);     // all rest
        chk("allrest_no_pulse", pulse_cnt - pbase, 0);

        // reset in the HOLD of note 9 (third pulse)
        pbase = pulse_cnt;
        start(FULL, 3);
        w = 0;
        while (pulse_cnt < pbase + 3 && w < 200) begin @(negedge clk); #1; w++; end
        if (pulse_cnt < pbase + 3) begin
            checks++;
            $display("FAIL reset_wait: only %0d pulses seen", pulse_cnt - pbase);
        end
        #2 reset = 1'b0;
        #1;
        chk("midrst_note", int'(note_out), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_new_note", int'(new_note), 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        start(FULL, 3); wait_done(0);

        // randomized replays
        for (int r = 0; r < 25; r++) begin
            logic [DEPTH*NOTE_W-1:0] n;
            for (int s = 0; s < DEPTH; s++)
                n[s*NOTE_W +: NOTE_W] = ($urandom_range(0, 2) == 0) ? 4'd0 : NOTE_W'($urandom);
            start(n, $urandom_range(0, 6));
            wait_done(1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
